// File: rtl/commu_pkg.sv
// Shared definitions for the communication sequencer.
//   state_e     : sequencer state encoding (4-bit)
//   PUSH_MIN    : smallest push-burst count a transaction may run
//   ERR_CNT_MAX : saturation value of the timeout counter
//   push_sat()  : clamp a configured push count to at least PUSH_MIN
//   in_txn()    : true for the states that belong to a head/push/tail frame
package commu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_BUF    = 4'd1,
    ST_GUARD  = 4'd2,
    ST_SLOT   = 4'd3,
    ST_FIRE_H = 4'd4,
    ST_WAIT_H = 4'd5,
    ST_FIRE_P = 4'd6,
    ST_WAIT_P = 4'd7,
    ST_FIRE_T = 4'd8,
    ST_WAIT_T = 4'd9,
    ST_DONE   = 4'd10,
    ST_ERR    = 4'd11
  } state_e;

  localparam logic [7:0] PUSH_MIN    = 8'd1;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  function automatic logic [7:0] push_sat(input logic [7:0] n);
    return (n < PUSH_MIN) ? PUSH_MIN : n;
  endfunction

  function automatic logic in_txn(input state_e s);
    return (s >= ST_FIRE_H) && (s <= ST_WAIT_T);
  endfunction

endpackage

// File: rtl/commu_rr_pick.sv
// Combinational round-robin picker.
//   en_i    : per-channel enable vector
//   last_i  : index of the most recently served channel
//   next_o  : first enabled index strictly after last_i, wrapping
//   found_o : high when any channel is enabled
module commu_rr_pick #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CH_W   = 3
) (
  input  logic [NUM_CH-1:0] en_i,
  input  logic [CH_W-1:0]   last_i,
  output logic [CH_W-1:0]   next_o,
  output logic              found_o
);

  int unsigned     idx;
  logic [CH_W-1:0] sel;

  // Scan offsets 1..NUM_CH so last_i itself is considered only after every
  // other channel, which also covers the single-enabled-channel case.
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = (32'(last_i) + k) % NUM_CH;
      sel = idx[CH_W-1:0];
      if (!found_o && en_i[sel]) begin
        found_o = 1'b1;
        next_o  = sel;
      end
    end
  end

endmodule

// File: rtl/commu_seq.sv
// Multi-channel communication sequencer. Frames each slot transmission as
// head, N pushes and tail, picks the channel round-robin, runs a guard
// period after each frame before announcing a slot, and aborts stalled
// phases with a timeout.
//   clk_sys, rst                 : clock, synchronous active-high reset
//   pk_frm                       : frame-active level
//   slot_rdy                     : slot request
//   cfg_sendEn                   : per-channel transmit enable
//   cfg_push_num                 : push bursts per transaction (0 acts as 1)
//   done_head/push/tail          : phase-complete pulses from the engines
//   fire_head/push/tail          : one-cycle phase start pulses
//   de                           : registered one-hot driver enable
//   ch_sel                       : channel of current/most recent transaction
//   slot_begin                   : one-cycle slot-start pulse
//   busy                         : state is not IDLE
//   err_timeout, err_cnt         : abort pulse, saturating abort count
module commu_seq
  import commu_pkg::*;
#(
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned CH_W    = 3,
  parameter int unsigned BUF_CYC = 100000,
  parameter int unsigned TO_CYC  = 1000000,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              pk_frm,
  input  logic              slot_rdy,
  input  logic [NUM_CH-1:0] cfg_sendEn,
  input  logic [7:0]        cfg_push_num,
  input  logic              done_head,
  input  logic              done_push,
  input  logic              done_tail,
  output logic              fire_head,
  output logic              fire_push,
  output logic              fire_tail,
  output logic [NUM_CH-1:0] de,
  output logic [CH_W-1:0]   ch_sel,
  output logic              slot_begin,
  output logic              busy,
  output logic              err_timeout,
  output logic [7:0]        err_cnt
);

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(BUF_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TO_CYC - 1);
  localparam logic [CH_W-1:0]  PTR_RST    = CH_W'(NUM_CH - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        push_left_q;
  logic [CH_W-1:0]   ch_sel_q;
  logic [CH_W-1:0]   ptr_q;
  logic [7:0]        err_cnt_q;
  logic [NUM_CH-1:0] de_q;

  logic [CH_W-1:0]   pick_ch;
  logic              pick_found;
  logic [NUM_CH-1:0] sel_mask;

  commu_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .en_i    (cfg_sendEn),
    .last_i  (ptr_q),
    .next_o  (pick_ch),
    .found_o (pick_found)
  );

  assign sel_mask = NUM_CH'(1) << ch_sel_q;

  // One counter serves both the guard period and the WAIT timeouts; the
  // state preceding each counted state clears it so every entry starts at 0.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      push_left_q <= '0;
      ch_sel_q    <= '0;
      ptr_q       <= PTR_RST;
      err_cnt_q   <= '0;
      de_q        <= '0;
    end else begin
      de_q <= in_txn(state_q) ? (sel_mask & cfg_sendEn) : '0;
      case (state_q)
        ST_IDLE: begin
          if (pk_frm) begin
            state_q <= ST_BUF;
          end else if (slot_rdy && pick_found) begin
            state_q     <= ST_FIRE_H;
            ch_sel_q    <= pick_ch;
            push_left_q <= push_sat(cfg_push_num);
          end
        end
        ST_BUF: begin
          cnt_q <= '0;
          if (!pk_frm) state_q <= ST_GUARD;
        end
        ST_GUARD: begin
          if (pk_frm)                    state_q <= ST_BUF;
          else if (cnt_q == GUARD_LAST)  state_q <= ST_SLOT;
          else                           cnt_q   <= cnt_q + CNT_W'(1);
        end
        ST_SLOT: state_q <= ST_IDLE;
        ST_FIRE_H: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_H;
        end
        ST_WAIT_H: begin
          if (done_head)              state_q <= ST_FIRE_P;
          else if (cnt_q == TO_LAST)  state_q <= ST_ERR;
          else                        cnt_q   <= cnt_q + CNT_W'(1);
        end
        ST_FIRE_P: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_P;
        end
        ST_WAIT_P: begin
          if (done_push) begin
            push_left_q <= push_left_q - 8'd1;
            state_q     <= (push_left_q > 8'd1) ? ST_FIRE_P : ST_FIRE_T;
          end else if (cnt_q == TO_LAST) begin
            state_q <= ST_ERR;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_FIRE_T: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_T;
        end
        ST_WAIT_T: begin
          if (done_tail)              state_q <= ST_DONE;
          else if (cnt_q == TO_LAST)  state_q <= ST_ERR;
          else                        cnt_q   <= cnt_q + CNT_W'(1);
        end
        ST_DONE: begin
          ptr_q   <= ch_sel_q;
          state_q <= ST_IDLE;
        end
        ST_ERR: begin
          // Advance past the failed channel so it is not retried at once.
          ptr_q   <= ch_sel_q;
          if (err_cnt_q != ERR_CNT_MAX) err_cnt_q <= err_cnt_q + 8'd1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fire_head   = (state_q == ST_FIRE_H);
  assign fire_push   = (state_q == ST_FIRE_P);
  assign fire_tail   = (state_q == ST_FIRE_T);
  assign slot_begin  = (state_q == ST_SLOT);
  assign err_timeout = (state_q == ST_ERR);
  assign busy        = (state_q != ST_IDLE);
  assign de          = de_q;
  assign ch_sel      = ch_sel_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_commu_seq.sv
module tb_commu_seq;

  localparam int unsigned NUM_CH  = 8;
  localparam int unsigned CH_W    = 3;
  localparam int unsigned BUF_CYC = 100;
  localparam int unsigned TO_CYC  = 50;
  localparam int unsigned CNT_W   = 32;

  localparam int K_H = 1, K_P = 2, K_T = 3, K_SLOT = 4, K_ERR = 5;

  logic              clk_sys = 1'b0;
  logic              rst = 1'b1;
  logic              pk_frm = 1'b0;
  logic              slot_rdy = 1'b0;
  logic [NUM_CH-1:0] cfg_sendEn = '0;
  logic [7:0]        cfg_push_num = '0;
  logic              done_head = 1'b0, done_push = 1'b0, done_tail = 1'b0;
  logic              fire_head, fire_push, fire_tail;
  logic [NUM_CH-1:0] de;
  logic [CH_W-1:0]   ch_sel;
  logic              slot_begin, busy, err_timeout;
  logic [7:0]        err_cnt;

  commu_seq #(
    .NUM_CH  (NUM_CH),
    .CH_W    (CH_W),
    .BUF_CYC (BUF_CYC),
    .TO_CYC  (TO_CYC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .pk_frm       (pk_frm),
    .slot_rdy     (slot_rdy),
    .cfg_sendEn   (cfg_sendEn),
    .cfg_push_num (cfg_push_num),
    .done_head    (done_head),
    .done_push    (done_push),
    .done_tail    (done_tail),
    .fire_head    (fire_head),
    .fire_push    (fire_push),
    .fire_tail    (fire_tail),
    .de           (de),
    .ch_sel       (ch_sel),
    .slot_begin   (slot_begin),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_cnt      (err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int                kind;
    int                ch;
    logic [NUM_CH-1:0] de;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  last_ch  = NUM_CH - 1;   // reference model: most recently served channel
  int  exp_err  = 0;            // reference model: expected err_cnt

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Reference round-robin: the lowest enabled channel above the last served
  // one, otherwise the lowest enabled channel overall.
  function automatic int rr_next(input logic [NUM_CH-1:0] en, input int last);
    int above = -1;
    int lowest = -1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en[i[CH_W-1:0]]) begin
        if (lowest < 0) lowest = i;
        if (above < 0 && i > last) above = i;
      end
    end
    return (above >= 0) ? above : lowest;
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input int ch);
    logic [NUM_CH-1:0] m = '0;
    m[ch[CH_W-1:0]] = 1'b1;
    return m;
  endfunction

  function automatic void push_ev(input int kind, input int ch, input logic [NUM_CH-1:0] d);
    ev_t e;
    e.kind = kind;
    e.ch   = ch;
    e.de   = d;
    exp_q.push_back(e);
  endfunction

  // Monitor: every observed pulse output is matched against the scoreboard.
  task automatic mon_ev(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", 32'(kind), 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", 32'(kind), 32'(e.kind));
      if (kind != K_SLOT) chk("ev_ch", 32'(ch_sel), 32'(e.ch));
      if (kind == K_P || kind == K_T || kind == K_ERR) chk("ev_de", 32'(de), 32'(e.de));
      if (kind == K_SLOT) chk("slot_de", 32'(de), 32'd0);
    end
  endtask

  always @(negedge clk_sys) begin
    if (!rst) begin
      if (fire_head)   mon_ev(K_H);
      if (fire_push)   mon_ev(K_P);
      if (fire_tail)   mon_ev(K_T);
      if (slot_begin)  mon_ev(K_SLOT);
      if (err_timeout) mon_ev(K_ERR);
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic fired(input int kind);
    case (kind)
      K_H:     return fire_head;
      K_P:     return fire_push;
      K_T:     return fire_tail;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_fire(input int kind);
    logic ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (fired(kind)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_fire", 32'(ok), 32'd1);
  endtask

  // mode 0: normal, 1: no done_push (timeout), 2: done_head at timer TO_CYC-1,
  // 3: reset while in WAIT_T
  task automatic run_txn(input logic [NUM_CH-1:0] en, input logic [7:0] pn,
                         input int dly_max, input bit drop_en, input int mode,
                         output int ch_got);
    int ch, np, d, n;
    logic [NUM_CH-1:0] en_t, dexp;
    ch   = rr_next(en, last_ch);
    np   = (pn == 8'd0) ? 1 : int'(pn);
    en_t = drop_en ? (en & ~onehot(ch)) : en;
    dexp = onehot(ch) & en_t;
    push_ev(K_H, ch, '0);
    if (mode == 1) begin
      push_ev(K_P, ch, dexp);
      push_ev(K_ERR, ch, dexp);
    end else begin
      for (int p = 0; p < np; p++) push_ev(K_P, ch, dexp);
      push_ev(K_T, ch, dexp);
    end
    cfg_sendEn   = en;
    cfg_push_num = pn;
    slot_rdy     = 1'b1;
    tick();
    slot_rdy = 1'b0;
    wait_fire(K_H);
    ch_got = int'(ch_sel);
    if (drop_en) cfg_sendEn = en_t;
    // head phase
    d = (mode == 2) ? int'(TO_CYC) - 1 : int'($urandom_range(dly_max));
    tick();
    repeat (d) tick();
    done_head = 1'b1;
    tick();
    done_head = 1'b0;
    if (mode == 2) chk("late_done_no_err", 32'(err_timeout), 32'd0);
    // push phases
    for (int p = 0; p < np; p++) begin
      wait_fire(K_P);
      tick();
      if (mode == 1) begin
        n = 0;
        while (!err_timeout && n < 200) begin
          tick();
          n++;
        end
        chk("timeout_latency", 32'(n), 32'(TO_CYC));
        tick();
        exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        last_ch = ch;
        chk("de_after_err", 32'(de), 32'd0);
        chk("err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("busy_after_err", 32'(busy), 32'd0);
        return;
      end
      d = int'($urandom_range(dly_max));
      repeat (d) tick();
      done_push = 1'b1;
      tick();
      done_push = 1'b0;
    end
    // tail phase
    wait_fire(K_T);
    tick();
    if (mode == 3) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      last_ch = NUM_CH - 1;
      exp_err = 0;
      chk("rst_de", 32'(de), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ch_sel", 32'(ch_sel), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      return;
    end
    d = int'($urandom_range(dly_max));
    repeat (d) tick();
    done_tail = 1'b1;
    tick();
    done_tail = 1'b0;
    tick();
    last_ch = ch;
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  // Guard timing; optionally re-assert pk_frm mid-guard, or raise slot_rdy
  // together with pk_frm to check that the frame wins.
  task automatic guard(input int hi, input bit reassert, input bit with_rdy);
    int n;
    push_ev(K_SLOT, 0, '0);
    cfg_sendEn = 8'hFF;
    pk_frm     = 1'b1;
    slot_rdy   = with_rdy;
    tick();
    slot_rdy = 1'b0;
    if (with_rdy) begin
      chk("prio_no_head", 32'(fire_head), 32'd0);
      chk("prio_busy", 32'(busy), 32'd1);
    end
    repeat (hi - 1) tick();
    pk_frm = 1'b0;
    if (reassert) begin
      repeat (40) tick();
      pk_frm = 1'b1;
      tick();
      pk_frm = 1'b0;
    end
    n = 0;
    while (!slot_begin && n < 300) begin
      tick();
      n++;
    end
    chk("guard_latency", 32'(n), 32'(BUF_CYC + 1));
    tick();
    chk("busy_after_slot", 32'(busy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int got;
    logic [NUM_CH-1:0] en;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_de", 32'(de), 32'd0);
    chk("reset_ch_sel", 32'(ch_sel), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);
    chk("reset_pulses", 32'({fire_head, fire_push, fire_tail, slot_begin, err_timeout}), 32'd0);

    // round robin over 8'b1010_0100
    run_txn(8'b1010_0100, 8'd1, 0, 1'b0, 0, got);
    chk("rr_first", 32'(got), 32'd2);
    run_txn(8'b1010_0100, 8'd1, 0, 1'b0, 0, got);
    chk("rr_second", 32'(got), 32'd5);
    run_txn(8'b1010_0100, 8'd1, 0, 1'b0, 0, got);
    chk("rr_third", 32'(got), 32'd7);

    // push counts
    run_txn(8'hFF, 8'd3, 2, 1'b0, 0, got);
    run_txn(8'hFF, 8'd0, 2, 1'b0, 0, got);

    // guard timing, restart, and frame priority
    guard(5, 1'b0, 1'b0);
    guard(5, 1'b1, 1'b0);
    guard(3, 1'b0, 1'b1);

    // empty enable
    cfg_sendEn = '0;
    slot_rdy   = 1'b1;
    tick();
    slot_rdy = 1'b0;
    chk("empty_busy", 32'(busy), 32'd0);
    tick();
    chk("empty_busy2", 32'(busy), 32'd0);

    // timeout, then done exactly at the last timer value
    run_txn(8'b0001_1000, 8'd1, 0, 1'b0, 1, got);
    run_txn(8'b0001_1000, 8'd2, 1, 1'b0, 2, got);

    // randomized transactions
    for (int t = 0; t < 25; t++) begin
      en = NUM_CH'($urandom_range(1, 255));
      run_txn(en, 8'($urandom_range(0, 4)), 3, ($urandom_range(0, 3) == 0), 0, got);
    end

    // reset mid-WAIT_T, then first enabled channel is served
    run_txn(NUM_CH'($urandom_range(1, 255)), 8'd1, 1, 1'b0, 3, got);
    run_txn(8'b0100_0101, 8'd1, 1, 1'b0, 0, got);
    chk("post_reset_ch", 32'(got), 32'd0);

    repeat (3) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
